// File: rtl/mp_arith_seq.sv
// mp_arith_seq: multi-precision add/subtract sequencer driving RF lane 0 and the AB.
// Accepts one N-word command, then walks operand/result registers one word
// per clock, chaining the ALU carry and accumulating aggregate flags.
// Optional feature macro: MP_ARITH_SEQ_ABORT_EN (adds abort_i / aborted_o).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, ready_o             command handshake (accepted in IDLE)
//   cmd_sub_i, carry_in_i, len_i command: op, word-0 carry, word count - 1
//   a_base_i, b_base_i, r_base_i base registers (least-significant word)
//   select_a/b/r_o, write_en_o   RF lane-0 read/write controls
//   ab_op_o, cf_o                AB opcode and carry in
//   alu_cf/zf/of/sf_i            per-word ALU flags
//   busy_o, done_o               RUN indicator, one-cycle completion pulse
//   res_cf/zf/of/sf_o            aggregate flags
//   abort_i, aborted_o           early termination (MP_ARITH_SEQ_ABORT_EN only)
module mp_arith_seq #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter logic [1:0]  ADD_OP        = 2'b00,
  parameter logic [1:0]  SUB_OP        = 2'b01
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic                     cmd_sub_i,
  input  logic                     carry_in_i,
  input  logic [ADDRESS_WIDTH-1:0] len_i,
  input  logic [ADDRESS_WIDTH-1:0] a_base_i,
  input  logic [ADDRESS_WIDTH-1:0] b_base_i,
  input  logic [ADDRESS_WIDTH-1:0] r_base_i,
  output logic [ADDRESS_WIDTH-1:0] select_a_o,
  output logic [ADDRESS_WIDTH-1:0] select_b_o,
  output logic [ADDRESS_WIDTH-1:0] select_r_o,
  output logic                     write_en_o,
  output logic [1:0]               ab_op_o,
  output logic                     cf_o,
  input  logic                     alu_cf_i,
  input  logic                     alu_zf_i,
  input  logic                     alu_of_i,
  input  logic                     alu_sf_i,
`ifdef MP_ARITH_SEQ_ABORT_EN
  input  logic                     abort_i,
  output logic                     aborted_o,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     res_cf_o,
  output logic                     res_zf_o,
  output logic                     res_of_o,
  output logic                     res_sf_o
);

  localparam int unsigned AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d, len_q, len_d;
  logic [AW-1:0] a_base_q, a_base_d, b_base_q, b_base_d, r_base_q, r_base_d;
  logic          sub_q, sub_d, c_q, c_d, zacc_q, zacc_d, of_q, of_d, sf_q, sf_d;
  logic          res_cf_d, res_zf_d, res_of_d, res_sf_d;
  logic          we_q, abort_hit, run_d;

`ifdef MP_ARITH_SEQ_ABORT_EN
  assign abort_hit = abort_i & (state_q == RUN);
`else
  assign abort_hit = 1'b0;
`endif

  // Write enable is dropped immediately when reset or abort arrives so the
  // current word is not committed.
  assign write_en_o = we_q & ~rst_i & ~abort_hit;

  // Next-state and datapath-register update
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    r_base_d = r_base_q;
    sub_d    = sub_q;
    c_d      = c_q;
    zacc_d   = zacc_q;
    of_d     = of_q;
    sf_d     = sf_q;
    res_cf_d = res_cf_o;
    res_zf_d = res_zf_o;
    res_of_d = res_of_o;
    res_sf_d = res_sf_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          k_d      = '0;
          len_d    = len_i;
          a_base_d = a_base_i;
          b_base_d = b_base_i;
          r_base_d = r_base_i;
          sub_d    = cmd_sub_i;
          c_d      = carry_in_i;
          zacc_d   = 1'b1;
          of_d     = 1'b0;
          sf_d     = 1'b0;
        end
      end
      RUN: begin
        if (abort_hit) begin
          // Report flags of the words completed so far
          state_d  = DONE;
          res_cf_d = c_q;
          res_zf_d = zacc_q;
          res_of_d = of_q;
          res_sf_d = sf_q;
        end else begin
          c_d    = alu_cf_i;
          zacc_d = zacc_q & alu_zf_i;
          of_d   = alu_of_i;
          sf_d   = alu_sf_i;
          k_d    = k_q + AW'(1);
          if (k_q == len_q) begin
            state_d  = DONE;
            res_cf_d = alu_cf_i;
            res_zf_d = zacc_q & alu_zf_i;
            res_of_d = alu_of_i;
            res_sf_d = alu_sf_i;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run_d = (state_d == RUN);

  // State and registered outputs, computed from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      len_q      <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      r_base_q   <= '0;
      sub_q      <= 1'b0;
      c_q        <= 1'b0;
      zacc_q     <= 1'b0;
      of_q       <= 1'b0;
      sf_q       <= 1'b0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      we_q       <= 1'b0;
      select_a_o <= '0;
      select_b_o <= '0;
      select_r_o <= '0;
      ab_op_o    <= 2'b00;
      cf_o       <= 1'b0;
      res_cf_o   <= 1'b0;
      res_zf_o   <= 1'b0;
      res_of_o   <= 1'b0;
      res_sf_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      r_base_q   <= r_base_d;
      sub_q      <= sub_d;
      c_q        <= c_d;
      zacc_q     <= zacc_d;
      of_q       <= of_d;
      sf_q       <= sf_d;
      ready_o    <= (state_d == IDLE);
      busy_o     <= run_d;
      done_o     <= (state_d == DONE);
      we_q       <= run_d;
      select_a_o <= run_d ? AW'(a_base_d + k_d) : '0;
      select_b_o <= run_d ? AW'(b_base_d + k_d) : '0;
      select_r_o <= run_d ? AW'(r_base_d + k_d) : '0;
      ab_op_o    <= run_d ? (sub_d ? SUB_OP : ADD_OP) : 2'b00;
      cf_o       <= run_d ? c_d : 1'b0;
      res_cf_o   <= res_cf_d;
      res_zf_o   <= res_zf_d;
      res_of_o   <= res_of_d;
      res_sf_o   <= res_sf_d;
    end
  end

`ifdef MP_ARITH_SEQ_ABORT_EN
  // Sticky abort indication, cleared by the next accepted command
  always_ff @(posedge clk_i) begin
    if (rst_i)                          aborted_o <= 1'b0;
    else if (state_q == IDLE && start_i) aborted_o <= 1'b0;
    else if (abort_hit)                 aborted_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mp_arith_seq.sv
// Self-checking bench for mp_arith_seq: a 32x32 register file and ALU around
// the DUT, with a word-serial big-number reference model for results/flags.
module tb_mp_arith_seq;

  localparam logic [1:0] ADD_OP = 2'b00;
  localparam logic [1:0] SUB_OP = 2'b01;

  logic       clk = 1'b0;
  logic       rst_i, start_i, cmd_sub_i, carry_in_i, abort_i;
  logic [4:0] len_i, a_base_i, b_base_i, r_base_i;
  logic [4:0] select_a_o, select_b_o, select_r_o;
  logic       write_en_o, ready_o, busy_o, done_o, cf_o, aborted_o;
  logic [1:0] ab_op_o;
  logic       alu_cf, alu_zf, alu_of, alu_sf;
  logic       res_cf_o, res_zf_o, res_of_o, res_sf_o;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic        tb_we;
  logic [4:0]  tb_addr;
  logic [31:0] tb_data;
  logic [31:0] alu_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mp_arith_seq dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
    .cmd_sub_i(cmd_sub_i), .carry_in_i(carry_in_i), .len_i(len_i),
    .a_base_i(a_base_i), .b_base_i(b_base_i), .r_base_i(r_base_i),
    .select_a_o(select_a_o), .select_b_o(select_b_o), .select_r_o(select_r_o),
    .write_en_o(write_en_o), .ab_op_o(ab_op_o), .cf_o(cf_o),
    .alu_cf_i(alu_cf), .alu_zf_i(alu_zf), .alu_of_i(alu_of), .alu_sf_i(alu_sf),
`ifdef MP_ARITH_SEQ_ABORT_EN
    .abort_i(abort_i), .aborted_o(aborted_o),
`endif
    .busy_o(busy_o), .done_o(done_o),
    .res_cf_o(res_cf_o), .res_zf_o(res_zf_o), .res_of_o(res_of_o), .res_sf_o(res_sf_o)
  );

`ifndef MP_ARITH_SEQ_ABORT_EN
  assign aborted_o = 1'b0;
`endif

  // ALU: subtract is a - b - borrow with carry meaning "no borrow"
  logic [32:0] w;
  longint      sres;
  always_comb begin
    if (ab_op_o == SUB_OP) begin
      w    = {1'b0, rf[select_a_o]} - {1'b0, rf[select_b_o]} - {32'd0, ~cf_o};
      sres = longint'($signed(rf[select_a_o])) - longint'($signed(rf[select_b_o])) - (cf_o ? 0 : 1);
      alu_cf = ~w[32];
    end else begin
      w    = {1'b0, rf[select_a_o]} + {1'b0, rf[select_b_o]} + {32'd0, cf_o};
      sres = longint'($signed(rf[select_a_o])) + longint'($signed(rf[select_b_o])) + (cf_o ? 1 : 0);
      alu_cf = w[32];
    end
    alu_res = w[31:0];
    alu_zf  = (alu_res == 32'd0);
    alu_sf  = alu_res[31];
    alu_of  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  end

  // Register file: bench loads take priority over DUT writes
  always @(posedge clk) begin
    if (tb_we)           rf[tb_addr] <= tb_data;
    else if (write_en_o) rf[select_r_o] <= alu_res;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int addr, input logic [31:0] data);
    tb_we = 1'b1; tb_addr = 5'(addr); tb_data = data;
    exp_rf[addr] = data;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Reference: apply n words of the multi-precision operation to exp_rf
  task automatic model(input bit sub, input bit cin, input int n, input int ab, input int bb,
                       input int rb, output bit cf, output bit zf, output bit of, output bit sf);
    logic [32:0] s;
    logic [31:0] a, bx;
    cf = cin; zf = 1'b1; of = 1'b0; sf = 1'b0;
    for (int i = 0; i < n; i++) begin
      a  = exp_rf[(ab + i) % 32];
      bx = sub ? ~exp_rf[(bb + i) % 32] : exp_rf[(bb + i) % 32];
      s  = {1'b0, a} + {1'b0, bx} + {32'd0, cf};
      exp_rf[(rb + i) % 32] = s[31:0];
      of = (a[31] == bx[31]) && (s[31] != a[31]);
      sf = s[31];
      zf = zf & (s[31:0] == 32'd0);
      cf = s[32];
    end
  endtask

  task automatic run_cmd(input bit sub, input bit cin, input int len, input int ab, input int bb,
                         input int rb, input int abort_at, input int rst_at, input int restart_at);
    int  writes = 0;
    int  done_at = -1;
    int  exp_words, exp_done, rf_bad;
    bit  sel_ok = 1'b1, op_ok = 1'b1;
    bit  mcf, mzf, mof, msf;
    exp_words = (abort_at > 0) ? abort_at - 1 : (rst_at > 0) ? rst_at - 1 : len + 1;
    exp_done  = (abort_at > 0) ? abort_at + 1 : (rst_at > 0) ? -1 : len + 2;
    @(posedge clk); #1;
    start_i = 1'b1; cmd_sub_i = sub; carry_in_i = cin; len_i = 5'(len);
    a_base_i = 5'(ab); b_base_i = 5'(bb); r_base_i = 5'(rb);
    @(negedge clk);
    chk("ready_at_start", ready_o, 1);
    for (int cyc = 1; cyc <= len + 4; cyc++) begin
      @(posedge clk); #1;
      start_i = (cyc == restart_at);
      rst_i   = (cyc == rst_at);
      abort_i = (cyc == abort_at);
      @(negedge clk);
      if (cyc == 1) chk("cf_o_word0", cf_o, cin);
      if (busy_o) begin
        if (ab_op_o !== (sub ? SUB_OP : ADD_OP)) op_ok = 1'b0;
      end else if (select_a_o !== 5'd0 || select_b_o !== 5'd0 || select_r_o !== 5'd0 ||
                   ab_op_o !== 2'b00 || write_en_o !== 1'b0) begin
        sel_ok = 1'b0;
      end
      if (write_en_o) begin
        if (select_a_o !== 5'((ab + writes) % 32) || select_b_o !== 5'((bb + writes) % 32) ||
            select_r_o !== 5'((rb + writes) % 32)) sel_ok = 1'b0;
        writes++;
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_res_clear", {res_cf_o, res_zf_o, res_of_o, res_sf_o}, 0);
      end
      if (done_o && done_at < 0) begin
        done_at = cyc;
        model(sub, cin, exp_words, ab, bb, rb, mcf, mzf, mof, msf);
        chk("res_flags", {res_cf_o, res_zf_o, res_of_o, res_sf_o}, {mcf, mzf, mof, msf});
        chk("aborted_o", aborted_o, (abort_at > 0));
        break;
      end
    end
    start_i = 1'b0; rst_i = 1'b0; abort_i = 1'b0;
    if (rst_at > 0) model(sub, cin, exp_words, ab, bb, rb, mcf, mzf, mof, msf);
    chk("done_cycle", 64'(done_at), 64'(exp_done));
    chk("write_count", 64'(writes), 64'(exp_words));
    chk("selects", sel_ok, 1);
    chk("ab_op_run", op_ok, 1);
    @(posedge clk); #1;
    rf_bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) rf_bad++;
    chk("rf_contents_bad_regs", 64'(rf_bad), 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; cmd_sub_i = 1'b0; carry_in_i = 1'b0; abort_i = 1'b0;
    len_i = '0; a_base_i = '0; b_base_i = '0; r_base_i = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", ready_o, 1);
    chk("reset_busy_done_we", {busy_o, done_o, write_en_o}, 0);
    chk("reset_selects", {select_a_o, select_b_o, select_r_o, ab_op_o, cf_o}, 0);
    chk("reset_res", {res_cf_o, res_zf_o, res_of_o, res_sf_o, aborted_o}, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 32; i++) poke(i, $urandom);

    // 2-word add with carry propagation
    poke(0, 32'hFFFF_FFFF); poke(1, 0); poke(2, 1); poke(3, 0);
    run_cmd(0, 0, 1, 0, 2, 4, 0, 0, 0);
    chk("add_r4", rf[4], 32'h0);
    chk("add_r5", rf[5], 32'h1);
    chk("add_cf_zf", {res_cf_o, res_zf_o}, 2'b00);

    // 2-word subtract, no incoming borrow
    run_cmd(1, 1, 1, 0, 2, 4, 0, 0, 0);
    chk("sub_r4", rf[4], 32'hFFFF_FFFE);
    chk("sub_r5", rf[5], 32'h0);

    // Single word, zero result
    poke(10, 5); poke(11, 5);
    run_cmd(1, 1, 0, 10, 11, 12, 0, 0, 0);
    chk("single_r12", rf[12], 32'h0);
    chk("single_zf", res_zf_o, 1);

    // Address wrap-around, in-place on A
    run_cmd(0, 0, 1, 31, 30, 31, 0, 0, 0);

    // Ignored restart in cycle 3, reset in cycle 4
    run_cmd(0, 1, 7, 8, 16, 20, 0, 4, 3);

`ifdef MP_ARITH_SEQ_ABORT_EN
    run_cmd(1, 1, 3, 0, 4, 8, 2, 0, 0);
    run_cmd(0, 0, 2, 1, 5, 9, 0, 0, 0);
    chk("aborted_cleared", aborted_o, 0);
`endif

    // Randomized commands, including overlapping ranges
    for (int t = 0; t < 24; t++) begin
      int l;
      l = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 7));
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l,
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_arith_seq.md
# mp_arith_seq

Multi-precision arithmetic sequencer for the core datapath. It accepts one command describing an N-word add or subtract, then steps the arithmetic block lane (lane 0) of the register file and ALU over consecutive registers, one word per clock. It chains the carry between words and reports aggregate flags at the end. It owns RF lane 0 select/write controls and the AB opcode/carry-in while busy.

## Interface
Parameters:
- ADDRESS_WIDTH, 5: RF register address width; word count and address arithmetic wrap modulo 2^ADDRESS_WIDTH.
- ADD_OP, 2'b00: AB opcode driven for add commands.
- SUB_OP, 2'b01: AB opcode driven for subtract commands.

Ports (clock is clk_i; reset is rst_i, synchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  command valid; accepted only when ready_o=1.
- ready_o  out  1  high in IDLE.
- cmd_sub_i  in  1  0=add, 1=subtract.
- carry_in_i  in  1  carry fed to word 0.
- len_i  in  ADDRESS_WIDTH  word count minus one (0 means 1 word; 31 means 32 words).
- a_base_i, b_base_i, r_base_i  in  ADDRESS_WIDTH  base register of operand A, operand B and the result (least-significant word).
- select_a_o, select_b_o, select_r_o  out  ADDRESS_WIDTH  RF lane-0 read/write selects.
- write_en_o  out  1  RF lane-0 write enable (enable_writing bit 0).
- ab_op_o  out  2  AB opcode.
- cf_o  out  1  carry into ALU.
- alu_cf_i, alu_zf_i, alu_of_i, alu_sf_i  in  1  ALU per-word flags, combinational from current selects.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle completion pulse.
- res_cf_o, res_zf_o, res_of_o, res_sf_o  out  1  aggregate flags, valid from done_o until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready_o=1. start_i=1 latches all command fields, clears the word index k=0, loads carry register c=carry_in_i, sets zacc=1, and moves to RUN.
- RUN, each cycle:
  - select_a_o=a_base+k, select_b_o=b_base+k, select_r_o=r_base+k, all modulo 2^ADDRESS_WIDTH.
  - write_en_o=1, ab_op_o=cmd_sub?SUB_OP:ADD_OP, cf_o=c.
  - At the clock edge: c<=alu_cf_i, zacc<=zacc&alu_zf_i, last of/sf captured, k<=k+1.
  - When k==len the state moves to DONE.
- DONE: lasts one cycle. done_o=1, then the state returns to IDLE.
- Aggregate flags:
  - res_cf_o = carry out of the final word.
  - res_zf_o = AND of all per-word zf.
  - res_of_o, res_sf_o = values from the final word.
- No hazard checking.
  - In-place operation (r_base equal to a_base or b_base) is legal, because word k is read before it is written.
  - A result range offset by a positive amount inside an operand range corrupts later operand words. This is defined behaviour and is not flagged.
- start_i while not IDLE is ignored; no queuing.

## Timing
- Reset values: state IDLE, ready_o=1, busy_o=0, done_o=0, write_en_o=0. All selects, ab_op_o, cf_o and all res_* are 0.
- Start accepted in cycle 0 → RUN during cycles 1..len+1, one RF write per cycle. DONE in cycle len+2. Next start accepted in cycle len+3.
- Outside RUN: write_en_o=0, and selects/ab_op_o/cf_o are held at 0.
- rst_i asserted mid-RUN: IDLE on the next edge with no further writes. Words already written stay written. res_* are cleared.
- rst_i has priority over start_i and abort_i.

## Configuration
- MP_ARITH_SEQ_ABORT_EN defined:
  - Adds input abort_i (1 bit) and output aborted_o (1 bit, reset 0).
  - abort_i=1 in RUN forces write_en_o=0 that cycle and moves to DONE.
  - In DONE: aborted_o=1 and done_o=1. res_* hold the flags captured from the words completed before the abort.
  - aborted_o clears on the next accepted start.
- Not defined: neither port exists, and RUN always runs len+1 words.

## Test plan
- 2-word add, carry propagation:
  - Stimulus: R0=FFFF_FFFF, R1=0, R2=1, R3=0; a_base=0, b_base=2, r_base=4, len=1, carry_in=0.
  - Required: R4=0, R5=1; res_cf=0, res_zf=0; done_o in cycle 3.
- 2-word subtract with borrow, same operands as above:
  - Stimulus: cmd_sub=1, carry_in set for no-borrow per the AB convention.
  - Required: R4=FFFF_FFFE, R5=0; ab_op_o=SUB_OP throughout RUN.
- len=0, single word:
  - Stimulus: R10=5, R11=5, subtract into R12.
  - Required: exactly one write_en_o cycle; R12=0; res_zf=1; done_o in cycle 2.
- Address wrap-around:
  - Stimulus: a_base=31, b_base=30, r_base=31, len=1.
  - Required: selects show A 31 then 0, B 30 then 31, R 31 then 0; two writes.
- Reset mid-operation and ignored restart:
  - Stimulus: len=7; start_i re-asserted in cycle 3; rst_i asserted in cycle 4.
  - Required: the restart is ignored; writes occur in cycles 1..3 only; IDLE after the edge; done_o never pulses.
- Abort (MP_ARITH_SEQ_ABORT_EN):
  - Stimulus: len=3, abort_i in cycle 2.
  - Required: writes in cycle 1 only; done_o=1 and aborted_o=1 in cycle 3.
